// File: rtl/alu_ctrl_pipe.sv
// Pipelined ALU control decoder: decodes {funct, alu_op} requests and queues
// the results in a small output FIFO. It also keeps a saturating illegal-op counter.
module alu_ctrl_pipe #(
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 3,
    parameter int SEL_W   = 3,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [OP_W-1:0]    alu_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   select,
    output logic               illegal,
    output logic [CNT_W-1:0]   err_count,
    input  logic               err_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [SEL_W-1:0] sel_mem [DEPTH];
    logic             ill_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic [SEL_W-1:0] dec_sel;
    logic             dec_ill;
    logic             push;
    logic             pop;

    // Full-width funct compare, so any nonzero upper funct bit falls to illegal
    always_comb begin
        dec_sel = '0;
        dec_ill = 1'b0;
        case (alu_op)
            OP_W'(0): dec_sel = SEL_W'(0);
            OP_W'(1): dec_sel = SEL_W'(1);
            OP_W'(2): begin
                case (funct)
                    FUNCT_W'(6'h20), FUNCT_W'(6'h21): dec_sel = SEL_W'(0);
                    FUNCT_W'(6'h22), FUNCT_W'(6'h23): dec_sel = SEL_W'(1);
                    FUNCT_W'(6'h24): dec_sel = SEL_W'(2);
                    FUNCT_W'(6'h25): dec_sel = SEL_W'(3);
                    FUNCT_W'(6'h00): dec_sel = SEL_W'(4);
                    FUNCT_W'(6'h02): dec_sel = SEL_W'(5);
                    FUNCT_W'(6'h2A): dec_sel = SEL_W'(6);
                    FUNCT_W'(6'h27): dec_sel = SEL_W'(7);
                    default:         dec_ill = 1'b1;
                endcase
            end
            OP_W'(3): dec_sel = SEL_W'(2);
            OP_W'(4): dec_sel = SEL_W'(3);
            OP_W'(5): dec_sel = SEL_W'(6);
            OP_W'(6): dec_sel = SEL_W'(4);
            default:  dec_ill = 1'b1;
        endcase
    end

    assign in_ready  = (occ != FULL);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign select    = out_valid ? sel_mem[rd_ptr] : '0;
    assign illegal   = out_valid ? ill_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sel_mem[i] <= '0;
                ill_mem[i] <= 1'b0;
            end
        end else if (push) begin
            sel_mem[wr_ptr] <= dec_sel;
            ill_mem[wr_ptr] <= dec_ill;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Clear wins over a same-cycle illegal push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (push && dec_ill && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: a queue-based reference model follows
// directed and random traffic, and a second instance exercises a 2-bit error counter.
module tb_alu_ctrl_pipe;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] funct;
    logic [2:0] alu_op;
    logic       out_ready;
    logic       err_clr;

    logic        in_ready;
    logic        out_valid;
    logic [2:0]  select;
    logic        illegal;
    logic [15:0] err_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [2:0]  s_select;
    logic        s_illegal;
    logic [1:0]  s_err_count;

    int checks;
    int failures;

    logic [3:0] mq[$];
    longint     err_main;
    longint     err_sat;

    int fn_code[10] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h00, 'h02, 'h2A, 'h27};
    int fn_sel[10]  = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7};
    int op_sel[8]   = '{0, 1, -1, 2, 3, 6, 4, -1};

    alu_ctrl_pipe #(.FUNCT_W(6), .OP_W(3), .SEL_W(3), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .select(select), .illegal(illegal), .err_count(err_count), .err_clr(err_clr)
    );

    alu_ctrl_pipe #(.FUNCT_W(6), .OP_W(3), .SEL_W(3), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .funct(funct), .alu_op(alu_op), .out_valid(s_out_valid), .out_ready(out_ready),
        .select(s_select), .illegal(s_illegal), .err_count(s_err_count), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: {illegal, select} from lookup tables
    function automatic logic [3:0] refDecode(input logic [5:0] f, input logic [2:0] op);
        int code;
        code = -1;
        if (op == 3'd2) begin
            for (int i = 0; i < 10; i++)
                if (int'(f) == fn_code[i]) code = fn_sel[i];
        end else begin
            code = op_sel[op];
        end
        if (code < 0) return 4'b1000;
        return {1'b0, 3'(code)};
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        logic [3:0] head;
        head = (mq.size() != 0) ? mq[0] : 4'b0000;
        checkOutput("out_valid", longint'(out_valid), longint'(mq.size() != 0));
        checkOutput("in_ready",  longint'(in_ready),  longint'(mq.size() != DEPTH));
        checkOutput("select",    longint'(select),    longint'(head[2:0]));
        checkOutput("illegal",   longint'(illegal),   longint'(head[3]));
        checkOutput("err_count", longint'(err_count), err_main);
        checkOutput("err_count_sat", longint'(s_err_count), err_sat);
    endtask

    // One cycle: drive after negedge, check, then advance the model across the edge
    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [2:0] op,
                                 input logic ordy, input logic clr);
        logic       do_push;
        logic       do_pop;
        logic [3:0] d;
        in_valid  = v;
        funct     = f;
        alu_op    = op;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        compareAll();
        do_push = v && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        d       = refDecode(f, op);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        if (clr) begin
            err_main = 0;
            err_sat  = 0;
        end else if (do_push && d[3]) begin
            if (err_main < 65535) err_main++;
            if (err_sat < 3) err_sat++;
        end
        @(negedge clk);
    endtask

    task automatic resetModel();
        mq.delete();
        err_main = 0;
        err_sat  = 0;
    endtask

    initial begin
        logic [5:0] rf;
        logic [2:0] rop;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        funct     = '0;
        alu_op    = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        resetModel();
        #2;
        compareAll();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] R-type funct sequence");
        foreach (fn_code[i])
            if (i != 1 && i != 3) applyStimulus(1'b1, 6'(fn_code[i]), 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);

        $display("[TB] backpressure with held third request");
        applyStimulus(1'b1, 6'h21, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'h23, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'h25, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'h25, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'h25, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'h25, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);

        $display("[TB] streaming non-R ops");
        for (int k = 0; k < 18; k++) begin
            case (k % 6)
                0: rop = 3'd0;
                1: rop = 3'd1;
                2: rop = 3'd3;
                3: rop = 3'd4;
                4: rop = 3'd5;
                default: rop = 3'd6;
            endcase
            applyStimulus(1'b1, 6'(k), rop, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);

        $display("[TB] illegal ops, clear, saturation");
        applyStimulus(1'b1, 6'h20, 3'd7, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'h3F, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'h01, 3'd2, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 6'h10, 3'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);

        $display("[TB] asynchronous reset with full FIFO");
        applyStimulus(1'b1, 6'h2A, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'h27, 3'd7, 1'b0, 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        resetModel();
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 6'h00, 3'd0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) rf = 6'($urandom);
            else rf = 6'(fn_code[$urandom_range(0, 9)]);
            rop = 3'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, rf, rop,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALU control decoder.
- Accepts {funct, alu_op} decode requests over a valid/ready handshake, decodes them to an ALU select code and an illegal-op flag, and buffers results in a DEPTH-entry output FIFO.
- Keeps a saturating count of illegal requests.
- Sits between instruction decode and the ALU stage, so that decode and execute can stall independently.

Parameters:
- FUNCT_W, 6: width of the funct field.
- OP_W, 3: width of alu_op.
- SEL_W, 3: width of select. Must be >= 3.
- DEPTH, 2: output FIFO entries. Must be a power of two and >= 2.
- CNT_W, 16: width of the illegal-op counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: request valid.
- in_ready, output, 1: block can accept a request.
- funct, input, FUNCT_W: R-type function field.
- alu_op, input, OP_W: main-control ALU op class.
- out_valid, output, 1: FIFO head valid.
- out_ready, input, 1: consumer accepts the head.
- select, output, SEL_W: decoded ALU select at the FIFO head.
- illegal, output, 1: head entry was an undefined op.
- err_count, output, CNT_W: saturating count of accepted illegal requests.
- err_clr, input, 1: synchronous clear of err_count.

Behaviour:
- Reset: rst_n low asynchronously empties the FIFO and clears pointers, occupancy and err_count.
  - While reset is asserted: out_valid=0, select=0, illegal=0, err_count=0, in_ready=1.
  - Reset asserted mid-operation discards all buffered entries. No partial output follows.
- Decode (combinational on the inputs, captured on push):
  - alu_op 0 (load/store ADD) -> 0.
  - alu_op 1 (branch SUB) -> 1.
  - alu_op 2 (R-type): decode funct:
    - 0x20 and 0x21 -> 0.
    - 0x22 and 0x23 -> 1.
    - 0x24 -> 2; 0x25 -> 3; 0x00 -> 4; 0x02 -> 5; 0x2A -> 6; 0x27 -> 7.
  - alu_op 3 (ANDI) -> 2.
  - alu_op 4 (ORI) -> 3.
  - alu_op 5 (SLTI) -> 6.
  - alu_op 6 (LUI shift) -> 4.
  - alu_op 7, or any unlisted funct under alu_op 2: select=0, illegal=1.
  - Codes are zero-extended to SEL_W. funct bits above 6 must be 0 to match; otherwise the request is illegal.
- Push: on a rising edge with in_valid && in_ready, the decoded entry is written at the write pointer.
  - in_ready = (occupancy != DEPTH), combinational from state only and never from out_ready.
  - There is no pass-through when the FIFO is full.
- Pop: on a rising edge with out_valid && out_ready, the read pointer advances.
  - out_valid = (occupancy != 0).
  - select and illegal show the head entry and are 0 when the FIFO is empty.
- Latency: a request accepted at edge N into an empty FIFO appears with out_valid=1 immediately after edge N. Accept-to-visible is 1 cycle.
- Throughput: 1 request per cycle while out_ready is held high.
- Simultaneous push and pop (0 < occupancy < DEPTH): both occur and occupancy is unchanged.
  - Push with an empty FIFO is a normal push. Pop is impossible while empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Ordering is strict FIFO. An entry is never dropped or duplicated.
- Stall: when out_valid=1 and out_ready=0, select and illegal hold stable until the pop.
- err_count:
  - Increments by 1 on each accepted (pushed) illegal request, not on pop.
  - Saturates at 2^CNT_W-1.
  - err_clr=1 forces it to 0 on the next edge. Clear has priority over a same-cycle increment, so the result is 0.
- in_valid while in_ready=0 has no effect. The producer must hold the request; this block does not check that.

Test Plan:
- Reset, then push alu_op=2 funct=0x20, 0x22, 0x24, 0x25, 0x00, 0x02, 0x2A, 0x27 with out_ready=1 -> select sequence 0,1,2,3,4,5,6,7, each one cycle after acceptance, illegal=0, err_count=0.
- out_ready=0, push 3 requests (DEPTH=2) -> in_ready drops after 2 accepts and the third is held. Raise out_ready -> heads pop in order, in_ready returns 1 the cycle after the first pop, and the third entry is delivered.
- Continuous in_valid=1, out_ready=1 with alu_op cycling 0,1,3,4,5,6 -> one output per cycle with selects 0,1,2,3,6,4, occupancy constant at 1, and the pointers wrap several times.
- alu_op=7, then alu_op=2 funct=0x3F -> two outputs with select=0, illegal=1, err_count=2. Assert err_clr on the same cycle as a third illegal push -> err_count=0.
- CNT_W=2, push 5 illegal requests -> err_count reads 1,2,3,3,3.
- Fill the FIFO, then pulse rst_n low mid-cycle -> out_valid, select, illegal and err_count go to 0 asynchronously and in_ready=1. After release, no stale entry ever appears.
